// File: rtl/pulse_width_meter_pkg.sv
// ----------------------------------------------------------------------------
// pulse_width_meter_pkg
// Shared types and default constants for the pulse width meter:
//   fsm_t     - measurement FSM states (IDLE until the first edge, then MEASURE)
//   report_t  - one completed-run report (level, length, short/long/sat flags)
//   DEF_*     - default counter widths and per-level run-length bounds
// ----------------------------------------------------------------------------
package pulse_width_meter_pkg;

    // Widest run-length counter the report structure can carry.
    localparam int LEN_W_MAX = 32;

    localparam int DEF_CNT_WIDTH  = 16;
    localparam int DEF_DROP_WIDTH = 8;
    localparam int DEF_LEN_0_MIN  = 10;
    localparam int DEF_LEN_0_MAX  = 20;
    localparam int DEF_LEN_1_MIN  = 30;
    localparam int DEF_LEN_1_MAX  = 40;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } fsm_t;

    // len is zero-extended from the configured counter width.
    typedef struct packed {
        logic                 level;
        logic [LEN_W_MAX-1:0] len;
        logic                 is_short;
        logic                 is_long;
        logic                 sat;
    } report_t;

endpackage

// File: rtl/pulse_width_meter_if.sv
// ----------------------------------------------------------------------------
// pulse_width_meter_if
// Valid/ready report bus of the pulse width meter.
//   o_valid  - report available (meter -> consumer)
//   i_ready  - consumer accepts the report (consumer -> meter)
//   o_level  - level of the reported run
//   o_len    - run length in clock cycles
//   o_short  - length below the minimum for o_level
//   o_long   - length above the maximum for o_level, or counter saturated
//   o_sat    - counter saturated during the run
// Modports: master = meter side, slave = consumer side.
// ----------------------------------------------------------------------------
interface pulse_width_meter_if
    import pulse_width_meter_pkg::*;
#(
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) ();

    logic                 o_valid;
    logic                 i_ready;
    logic                 o_level;
    logic [CNT_WIDTH-1:0] o_len;
    logic                 o_short;
    logic                 o_long;
    logic                 o_sat;

    modport master (
        output o_valid, o_level, o_len, o_short, o_long, o_sat,
        input  i_ready
    );

    modport slave (
        input  o_valid, o_level, o_len, o_short, o_long, o_sat,
        output i_ready
    );

endinterface

// File: rtl/run_length_counter.sv
// ----------------------------------------------------------------------------
// run_length_counter
// Registers the monitored level, detects level changes and counts how many
// clock edges the registered level has been held.
//   i_clk    - clock
//   i_a_rst  - asynchronous active-high reset
//   i_state  - monitored level
//   o_s_q    - registered level (level of the run being counted)
//   o_edge   - i_state differs from o_s_q at this edge (combinational)
//   o_cnt    - run length so far, saturating at all-ones
//   o_sat    - an increment was blocked during the current run
// ----------------------------------------------------------------------------
module run_length_counter
    import pulse_width_meter_pkg::*;
#(
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 i_clk,
    input  logic                 i_a_rst,
    input  logic                 i_state,
    output logic                 o_s_q,
    output logic                 o_edge,
    output logic [CNT_WIDTH-1:0] o_cnt,
    output logic                 o_sat
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_WIDTH'(1);
    endfunction

    logic                 r_s_q;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_sat;
    logic                 w_edge;

    assign w_edge = (i_state != r_s_q);

    always_ff @(posedge i_clk or posedge i_a_rst) begin
        if (i_a_rst) begin
            r_s_q <= 1'b0;
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else begin
            r_s_q <= i_state;
            if (w_edge) begin
                // New run: this edge is its first sampled cycle.
                r_cnt <= CNT_WIDTH'(1);
                r_sat <= 1'b0;
            end else begin
                r_cnt <= sat_inc(r_cnt);
                if (r_cnt == CNT_MAX) begin
                    r_sat <= 1'b1;
                end
            end
        end
    end

    assign o_s_q  = r_s_q;
    assign o_edge = w_edge;
    assign o_cnt  = r_cnt;
    assign o_sat  = r_sat;

endmodule

// File: rtl/pulse_width_meter.sv
// ----------------------------------------------------------------------------
// pulse_width_meter
// Measures every completed run of constant level on i_state, checks it
// against per-level min/max bounds and emits one report per run on a
// valid/ready bus. The run in progress at reset has an unknown start and is
// never reported.
//   i_clk       - clock
//   i_a_rst     - asynchronous active-high reset
//   i_state     - monitored level
//   i_clr       - pulse clearing o_err and o_drop_cnt (a coincident set wins)
//   rpt         - report bus (master side), see pulse_width_meter_if
//   o_drop_cnt  - reports discarded under backpressure, saturating
//   o_err       - sticky: short, long, sat or drop seen since reset/clear
// ----------------------------------------------------------------------------
module pulse_width_meter
    import pulse_width_meter_pkg::*;
#(
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int LEN_0_MIN  = DEF_LEN_0_MIN,
    parameter int LEN_0_MAX  = DEF_LEN_0_MAX,
    parameter int LEN_1_MIN  = DEF_LEN_1_MIN,
    parameter int LEN_1_MAX  = DEF_LEN_1_MAX,
    parameter int DROP_WIDTH = DEF_DROP_WIDTH
) (
    input  logic                    i_clk,
    input  logic                    i_a_rst,
    input  logic                    i_state,
    input  logic                    i_clr,
    pulse_width_meter_if.master     rpt,
    output logic [DROP_WIDTH-1:0]   o_drop_cnt,
    output logic                    o_err
);

    localparam longint CNT_LIMIT = (longint'(1) << CNT_WIDTH) - 1;

    if (CNT_WIDTH > LEN_W_MAX) begin : g_bad_width
        $error("pulse_width_meter: CNT_WIDTH exceeds report length field");
    end
    if ((LEN_0_MIN > LEN_0_MAX) || (LEN_1_MIN > LEN_1_MAX)) begin : g_bad_order
        $error("pulse_width_meter: a MIN bound exceeds its MAX bound");
    end
    if ((LEN_0_MAX >= CNT_LIMIT) || (LEN_1_MAX >= CNT_LIMIT)) begin : g_bad_max
        $error("pulse_width_meter: a MAX bound is not below counter saturation");
    end

    function automatic logic [DROP_WIDTH-1:0] drop_inc(input logic [DROP_WIDTH-1:0] v);
        return (&v) ? v : v + DROP_WIDTH'(1);
    endfunction

    logic                  w_s_q;
    logic                  w_edge;
    logic [CNT_WIDTH-1:0]  w_cnt;
    logic                  w_sat;

    run_length_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_rlc (
        .i_clk   (i_clk),
        .i_a_rst (i_a_rst),
        .i_state (i_state),
        .o_s_q   (w_s_q),
        .o_edge  (w_edge),
        .o_cnt   (w_cnt),
        .o_sat   (w_sat)
    );

    // FSM: only edges seen in MEASURE close a run with a known start.
    fsm_t r_state;
    fsm_t w_state_nxt;
    logic w_complete;

    always_ff @(posedge i_clk or posedge i_a_rst) begin
        if (i_a_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_complete  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_edge) begin
                    w_state_nxt = MEASURE;
                end
            end
            MEASURE: begin
                w_complete = w_edge;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Stage p0: classify the run that closes at this edge.
    logic [CNT_WIDTH-1:0] w_min_p0;
    logic [CNT_WIDTH-1:0] w_max_p0;
    report_t              w_rpt_p0;

    assign w_min_p0 = w_s_q ? CNT_WIDTH'(LEN_1_MIN) : CNT_WIDTH'(LEN_0_MIN);
    assign w_max_p0 = w_s_q ? CNT_WIDTH'(LEN_1_MAX) : CNT_WIDTH'(LEN_0_MAX);

    always_comb begin
        w_rpt_p0          = '0;
        w_rpt_p0.level    = w_s_q;
        w_rpt_p0.len      = LEN_W_MAX'(w_cnt);
        w_rpt_p0.is_short = (w_cnt < w_min_p0);
        w_rpt_p0.is_long  = (w_cnt > w_max_p0) || w_sat;
        w_rpt_p0.sat      = w_sat;
    end

    // A new report may enter whenever the holding register is empty or
    // is being emptied in this very cycle.
    logic w_load;
    logic w_drop;
    logic w_err_set;

    assign w_load    = w_complete && (!rpt.o_valid || rpt.i_ready);
    assign w_drop    = w_complete && rpt.o_valid && !rpt.i_ready;
    assign w_err_set = (w_load && (w_rpt_p0.is_short || w_rpt_p0.is_long || w_rpt_p0.sat))
                     || w_drop;

    // Stage p1: report holding register plus drop/error bookkeeping.
    report_t               r_rpt_p1;
    logic                  r_vld_p1;
    logic [DROP_WIDTH-1:0] r_drop_cnt;
    logic                  r_err;

    always_ff @(posedge i_clk or posedge i_a_rst) begin
        if (i_a_rst) begin
            r_rpt_p1   <= '0;
            r_vld_p1   <= 1'b0;
            r_drop_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_load) begin
                r_rpt_p1 <= w_rpt_p0;
                r_vld_p1 <= 1'b1;
            end else if (rpt.i_ready) begin
                r_vld_p1 <= 1'b0;
            end

            // A drop coinciding with a clear restarts the count at one.
            if (w_drop) begin
                r_drop_cnt <= i_clr ? DROP_WIDTH'(1) : drop_inc(r_drop_cnt);
            end else if (i_clr) begin
                r_drop_cnt <= '0;
            end

            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (i_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    // Upper length bits are zero-extension only.
    if (CNT_WIDTH < LEN_W_MAX) begin : g_len_hi
        logic w_unused_len_hi;
        assign w_unused_len_hi = ^r_rpt_p1.len[LEN_W_MAX-1:CNT_WIDTH];
    end

    assign rpt.o_valid = r_vld_p1;
    assign rpt.o_level = r_rpt_p1.level;
    assign rpt.o_len   = r_rpt_p1.len[CNT_WIDTH-1:0];
    assign rpt.o_short = r_rpt_p1.is_short;
    assign rpt.o_long  = r_rpt_p1.is_long;
    assign rpt.o_sat   = r_rpt_p1.sat;
    assign o_drop_cnt  = r_drop_cnt;
    assign o_err       = r_err;

endmodule

// File: tb/tb_pulse_width_meter.sv
// ----------------------------------------------------------------------------
// tb_pulse_width_meter
// Directed scenarios plus randomized runs for pulse_width_meter (CNT_WIDTH=8),
// compared every cycle against a run-based reference model.
// ----------------------------------------------------------------------------
module tb_pulse_width_meter;
    import pulse_width_meter_pkg::*;

    localparam int CW    = 8;
    localparam int DW    = 8;
    localparam int L0MIN = DEF_LEN_0_MIN;
    localparam int L0MAX = DEF_LEN_0_MAX;
    localparam int L1MIN = DEF_LEN_1_MIN;
    localparam int L1MAX = DEF_LEN_1_MAX;
    localparam int CMAX  = (1 << CW) - 1;
    localparam int DMAX  = (1 << DW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          st;
    logic          clr;
    logic [DW-1:0] drop_cnt;
    logic          err;

    always #5 clk = ~clk;

    pulse_width_meter_if #(.CNT_WIDTH(CW)) rpt_if ();

    pulse_width_meter #(
        .CNT_WIDTH  (CW),
        .LEN_0_MIN  (L0MIN),
        .LEN_0_MAX  (L0MAX),
        .LEN_1_MIN  (L1MIN),
        .LEN_1_MAX  (L1MAX),
        .DROP_WIDTH (DW)
    ) dut (
        .i_clk      (clk),
        .i_a_rst    (rst),
        .i_state    (st),
        .i_clr      (clr),
        .rpt        (rpt_if),
        .o_drop_cnt (drop_cnt),
        .o_err      (err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, want %0d", tag, $time, act, exp);
        end
    endtask

    // Reference model: a run is tracked as an unbounded integer length of the
    // registered level; saturation is derived from it when the run closes.
    bit m_s, m_started;
    int m_run;
    bit m_valid, m_level, m_short, m_long, m_sat, m_err;
    int m_len, m_drop;

    task automatic model_reset();
        m_s = 0; m_started = 0; m_run = 0;
        m_valid = 0; m_level = 0; m_short = 0; m_long = 0; m_sat = 0;
        m_len = 0; m_drop = 0; m_err = 0;
    endtask

    task automatic model_step(input bit x, input bit rdy, input bit c);
        bit chg, done, ld, dr, sa, sh, lg, lv;
        int ln;
        chg  = (x != m_s);
        done = chg && m_started;
        lv   = m_s;
        sa   = (m_run > CMAX);
        ln   = sa ? CMAX : m_run;
        sh   = ln < (lv ? L1MIN : L0MIN);
        lg   = sa || (ln > (lv ? L1MAX : L0MAX));
        ld   = done && (!m_valid || rdy);
        dr   = done && m_valid && !rdy;
        if (ld) begin
            m_valid = 1; m_level = lv; m_len = ln;
            m_short = sh; m_long = lg; m_sat = sa;
        end else if (rdy) begin
            m_valid = 0;
        end
        if (c)                        m_drop = dr ? 1 : 0;
        else if (dr && m_drop < DMAX) m_drop++;
        if ((ld && (sh || lg || sa)) || dr) m_err = 1;
        else if (c)                         m_err = 0;
        if (chg) begin
            m_started = 1;
            m_run     = 1;
        end else begin
            m_run++;
        end
        m_s = x;
    endtask

    task automatic compare_all();
        check("valid", rpt_if.o_valid, m_valid);
        check("level", rpt_if.o_level, m_level);
        check("len",   rpt_if.o_len,   m_len);
        check("short", rpt_if.o_short, m_short);
        check("long",  rpt_if.o_long,  m_long);
        check("sat",   rpt_if.o_sat,   m_sat);
        check("drop",  drop_cnt,       m_drop);
        check("err",   err,            m_err);
    endtask

    // Inputs change one time unit after the active edge; outputs are sampled
    // one time unit after the following edge.
    task automatic cycle(input bit lvl, input bit rdy, input bit c);
        st = lvl; rpt_if.i_ready = rdy; clr = c;
        @(posedge clk);
        model_step(lvl, rdy, c);
        #1;
        compare_all();
    endtask

    task automatic run(input bit lvl, input int n, input bit rdy);
        repeat (n) cycle(lvl, rdy, 1'b0);
    endtask

    task automatic expect_rpt(input string tag, input bit lvl, input int len,
                              input bit sh, input bit lg, input bit sa);
        check({tag, "_valid"}, rpt_if.o_valid, 1);
        check({tag, "_level"}, rpt_if.o_level, lvl);
        check({tag, "_len"},   rpt_if.o_len,   len);
        check({tag, "_short"}, rpt_if.o_short, sh);
        check({tag, "_long"},  rpt_if.o_long,  lg);
        check({tag, "_sat"},   rpt_if.o_sat,   sa);
    endtask

    task automatic expect_zero(input string tag);
        check({tag, "_valid"}, rpt_if.o_valid, 0);
        check({tag, "_level"}, rpt_if.o_level, 0);
        check({tag, "_len"},   rpt_if.o_len,   0);
        check({tag, "_short"}, rpt_if.o_short, 0);
        check({tag, "_long"},  rpt_if.o_long,  0);
        check({tag, "_sat"},   rpt_if.o_sat,   0);
        check({tag, "_drop"},  drop_cnt,       0);
        check({tag, "_err"},   err,            0);
    endtask

    initial begin
        rst = 1'b1; st = 1'b0; clr = 1'b0; rpt_if.i_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        expect_zero("rst0");
        rst = 1'b0;

        // 1: first run unreported, then a legal level-1 run of 35
        run(0, 15, 1);
        run(1, 35, 1);
        cycle(0, 1, 0);
        expect_rpt("t1", 1, 35, 0, 0, 0);
        check("t1_err", err, 0);

        // 2: short level-1 run of 25, long level-0 run of 22
        run(0, 11, 1);
        cycle(1, 1, 0);
        expect_rpt("t2a", 0, 12, 0, 0, 0);
        run(1, 24, 1);
        cycle(0, 1, 0);
        expect_rpt("t2b", 1, 25, 1, 0, 0);
        check("t2b_err", err, 1);
        run(0, 21, 1);
        cycle(1, 1, 0);
        expect_rpt("t2c", 0, 22, 0, 1, 0);

        // 3: backpressure, runs of 12, 33, 15 with ready low
        run(1, 30, 1);
        cycle(0, 1, 0);
        run(0, 3, 1);
        check("t3_empty", rpt_if.o_valid, 0);
        run(0, 8, 0);
        cycle(1, 0, 0);
        expect_rpt("t3a", 0, 12, 0, 0, 0);
        run(1, 32, 0);
        cycle(0, 0, 0);
        check("t3_drop1", drop_cnt, 1);
        run(0, 14, 0);
        cycle(1, 0, 0);
        expect_rpt("t3b", 0, 12, 0, 0, 0);
        check("t3_drop2", drop_cnt, 2);
        check("t3_err", err, 1);
        cycle(1, 1, 0);
        check("t3_xfer_once", rpt_if.o_valid, 0);
        cycle(1, 1, 0);
        check("t3_still_empty", rpt_if.o_valid, 0);

        // 4: level 1 held for 300 cycles saturates the counter
        run(1, 298, 1);
        cycle(0, 1, 0);
        expect_rpt("t4", 1, CMAX, 0, 1, 1);

        // 5: asynchronous reset at cnt=12 with a report held and drops counted
        run(0, 14, 0);
        cycle(1, 0, 0);
        check("t5_pre_drop", drop_cnt, 3);
        run(1, 11, 0);
        #2;
        rst = 1'b1;
        #1;
        expect_zero("t5_rst");
        model_reset();
        #2;
        rst = 1'b0;
        cycle(1, 1, 0);
        check("t5_no_rpt", rpt_if.o_valid, 0);
        run(1, 31, 1);
        cycle(0, 1, 0);
        expect_rpt("t5", 1, 32, 0, 0, 0);
        check("t5_err", err, 0);
        check("t5_drop", drop_cnt, 0);

        // 6: clear coinciding with a short report, then a clear alone
        run(0, 4, 1);
        cycle(1, 1, 1);
        expect_rpt("t6", 0, 5, 1, 0, 0);
        check("t6_err_set_wins", err, 1);
        run(1, 2, 1);
        cycle(1, 1, 1);
        check("t6_err_clr", err, 0);
        check("t6_drop_clr", drop_cnt, 0);

        // clear coinciding with a drop restarts the count at one
        run(1, 31, 0);
        cycle(0, 0, 0);
        run(0, 10, 0);
        cycle(1, 0, 1);
        check("t7_drop_clr_set", drop_cnt, 1);
        check("t7_err", err, 1);

        // randomized runs, ready and clear
        for (int r = 0; r < 60; r++) begin
            int n;
            bit lvl;
            lvl = r[0];
            n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(250, 260))
                                            : int'($urandom_range(1, 45));
            for (int k = 0; k < n; k++) begin
                cycle(lvl, $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pulse_width_meter.md
# pulse_width_meter

Downstream monitor for a single-bit, slowly toggling state signal such as the randomized on/off stimulus used in our benches. It measures every completed run of constant level in clock cycles and checks it against per-level min/max bounds. Each measurement is emitted as a report over a valid/ready handshake. The block is synthesizable, so the same checker serves both the testbench and on-chip debug.

## Interface
- `CNT_WIDTH`, 16, width of the run-length counter and of `o_len`
- `LEN_0_MIN`, 10, minimum legal length of a level-0 run, in cycles
- `LEN_0_MAX`, 20, maximum legal length of a level-0 run, in cycles
- `LEN_1_MIN`, 30, minimum legal length of a level-1 run, in cycles
- `LEN_1_MAX`, 40, maximum legal length of a level-1 run, in cycles
- `DROP_WIDTH`, 8, width of the drop counter
- `i_clk` in 1: the single clock.
- `i_a_rst` in 1: reset, asynchronous and active-high.
- `i_state` in 1: monitored level, synchronous to `i_clk`.
- `i_ready` in 1: consumer accepts the report.
- `i_clr` in 1: single-cycle pulse that clears `o_err` and `o_drop_cnt`.
- `o_valid` out 1: report available.
- `o_level` out 1: level of the reported run.
- `o_len` out `CNT_WIDTH`: run length in cycles.
- `o_short` out 1: `o_len` is below the min for `o_level`.
- `o_long` out 1: `o_len` is above the max for `o_level`.
- `o_sat` out 1: the counter saturated during this run.
- `o_drop_cnt` out `DROP_WIDTH`: reports lost to backpressure; saturating.
- `o_err` out 1: sticky flag for any short, long, sat or drop since reset or the last `i_clr`.

## Operation
- `s_q` registers `i_state` every cycle. An edge is the condition `i_state != s_q` at a clock edge.
- Two-state FSM:
  - IDLE, entered on reset. The first run has an unknown start, so it is not reported. On the first edge, go to MEASURE and set `cnt` to 1.
  - MEASURE, held until reset.
- `cnt` behaviour:
  - On an edge, `cnt` becomes 1.
  - Otherwise `cnt` increments, saturating at 2^`CNT_WIDTH`−1.
  - `sat_q` is set when the increment is blocked and is cleared on an edge.
- An edge in MEASURE completes a run with level `s_q`, length `cnt` and sat `sat_q`.
- Checks use unsigned compares at `CNT_WIDTH` bits against the bounds for the completed level. A saturated run is also flagged `o_long`.
- Report register:
  - Loaded when a run completes and (`!o_valid` or `i_ready`).
  - Transfer occurs when `o_valid && i_ready`. Report data is stable while `o_valid && !i_ready`.
  - On a transfer with no new report, `o_valid` clears.
- Transfer and completion in the same cycle: the new report loads, `o_valid` stays 1, and nothing is dropped.
- Completion while `o_valid && !i_ready`: the held report is kept, the new one is discarded, and `o_drop_cnt` increments, saturating.
- `o_err` is set when a loaded report has `o_short`, `o_long` or `o_sat`, or when a drop occurs.
- `i_clr` clears `o_err` and `o_drop_cnt`. If a set event coincides with `i_clr`, the set wins: `o_err` = 1 and `o_drop_cnt` = 1 if that event is a drop.
- Reset mid-run:
  - All state clears immediately.
  - The FSM returns to IDLE.
  - The partial run and any pending report are lost and not counted as drops.
- An elaboration-time `$error` fires if any MIN > MAX, or if any MAX ≥ 2^`CNT_WIDTH`−1.

## Timing
- Reset values: `o_valid`, `o_level`, `o_short`, `o_long`, `o_sat`, `o_err` = 0; `o_len` = 0; `o_drop_cnt` = 0.
- `s_q` and `cnt` take their reset values as well (`cnt` = 0).
- Latency: when `i_state` changes before clock edge k, the report is valid after edge k. This is one register stage and there is no combinational path from input to output.
- Run length equals the number of rising clock edges at which `s_q` held that level. Example: `i_state` is 1 for exactly N sampled cycles, so `o_len` = N.
- Throughput is one report per cycle; the minimum run length is 1.

## Structure
- `pulse_width_meter_pkg` holds:
  - the `report_t` typedef packing level, len, short, long and sat;
  - the `fsm_t` enum (IDLE, MEASURE);
  - the default bound constants.
- The natural sub-module is `run_length_counter`, containing `s_q`, edge detect, the saturating `cnt` and `sat_q`.
- The top level holds the FSM, bound checks, report register, drop counter and sticky error.

## Test plan
All scenarios use the default parameters with `CNT_WIDTH`=8.
1. Reset with `i_state`=0; hold 0 for 15 cycles, then 1 for 35, then 0. Expect no report for the first run, then a single report: `o_level`=1, `o_len`=35, all flags 0, `o_err`=0.
2. Drive a level-1 run of 25 cycles, then a level-0 run of 22. Expect reports (1, 25, `o_short`) and (0, 22, `o_long`); `o_err`=1 after the first report.
3. Hold `i_ready`=0 and complete runs of 12, 33 and 15. Expect the first report held stable, `o_drop_cnt`=2 and `o_err`=1. Raising `i_ready` yields exactly one transfer of len 12.
4. Hold level 1 for 300 cycles. Expect `o_len`=255 with `o_sat`=1 and `o_long`=1.
5. Assert `i_a_rst` asynchronously at `cnt`=12 of a run. Expect all outputs 0 before the next clock. Expect no report at the next edge, and a correct report for the run after it.
6. Pulse `i_clr` in the same cycle that a short report loads. Expect `o_err`=1. A later `i_clr` alone gives `o_err`=0 and `o_drop_cnt`=0.
